// File: rtl/uart_dma_loader.sv
// uart_dma_loader
// Boot-time and run-time DMA front end between the UART and the memory hub.
// At boot: sends a request byte, receives a little-endian word count N, then
// forwards N instruction words as instr_ready pulses (capped at
// MAX_INSTR_WORDS), then sends an acknowledge byte. Afterwards every 4
// received bytes become one mem_ready pulse. UartTx is driven only while booting.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   rx_ready, rdata   received byte strobe and value
//   tx_busy           UartTx busy
//   tx_start, sdata   one-cycle transmit strobe and byte
//   instr_ready       one-cycle pulse, data holds an instruction word
//   mem_ready         one-cycle pulse, data holds an input-data word
//   data              last assembled word
//   program_loaded    high once the run state is entered
//   instr_count       instruction words forwarded so far
module uart_dma_loader #(
  parameter logic [7:0]  BOOT_REQ_BYTE   = 8'h99,
  parameter logic [7:0]  BOOT_ACK_BYTE   = 8'hAA,
  parameter int unsigned MAX_INSTR_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  rdata,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  sdata,
  output logic        instr_ready,
  output logic        mem_ready,
  output logic [31:0] data,
  output logic        program_loaded,
  output logic [31:0] instr_count
);

  localparam logic [31:0] MAX_WORDS = 32'(MAX_INSTR_WORDS);

  typedef enum logic [2:0] {
    S_REQ,
    S_LEN,
    S_INSTR,
    S_ACK,
    S_RUN
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] shift_q;
  logic [31:0] word_total;
  logic [31:0] words_seen;

  logic        accept;
  logic        word_done;
  logic [31:0] word;

  // The 4th byte is used directly from rdata so the word completes on the
  // same edge it is accepted; the state being left owns that word.
  always_comb begin
    accept    = rx_ready && (state != S_REQ);
    word_done = accept && (byte_idx == 2'd3);
    word      = {rdata, shift_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_REQ;
      byte_idx       <= '0;
      shift_q        <= '0;
      word_total     <= '0;
      words_seen     <= '0;
      tx_start       <= 1'b0;
      sdata          <= '0;
      instr_ready    <= 1'b0;
      mem_ready      <= 1'b0;
      data           <= '0;
      program_loaded <= 1'b0;
      instr_count    <= '0;
    end else begin
      tx_start    <= 1'b0;
      instr_ready <= 1'b0;
      mem_ready   <= 1'b0;

      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    shift_q[7:0]   <= rdata;
          2'd1:    shift_q[15:8]  <= rdata;
          2'd2:    shift_q[23:16] <= rdata;
          default: ;
        endcase
        if (word_done) data <= word;
      end

      case (state)
        S_REQ: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            sdata    <= BOOT_REQ_BYTE;
            state    <= S_LEN;
          end
        end
        S_LEN: begin
          if (word_done) begin
            word_total <= word;
            words_seen <= '0;
            state      <= (word == '0) ? S_ACK : S_INSTR;
          end
        end
        S_INSTR: begin
          if (word_done) begin
            if (instr_count < MAX_WORDS) begin
              instr_ready <= 1'b1;
              instr_count <= instr_count + 32'd1;
            end
            words_seen <= words_seen + 32'd1;
            if (words_seen + 32'd1 == word_total) state <= S_ACK;
          end
        end
        S_ACK: begin
          if (word_done) mem_ready <= 1'b1;
          if (!tx_busy && !tx_start) begin
            tx_start       <= 1'b1;
            sdata          <= BOOT_ACK_BYTE;
            program_loaded <= 1'b1;
            state          <= S_RUN;
          end
        end
        S_RUN: begin
          if (word_done) mem_ready <= 1'b1;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dma_loader.sv
module tb_uart_dma_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rdata = '0;
  logic        tx_busy = 1'b1;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        instr_ready;
  logic        mem_ready;
  logic [31:0] data;
  logic        program_loaded;
  logic [31:0] instr_count;

  uart_dma_loader #(
    .BOOT_REQ_BYTE(8'h99),
    .BOOT_ACK_BYTE(8'hAA),
    .MAX_INSTR_WORDS(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx_ready(rx_ready),
    .rdata(rdata),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .sdata(sdata),
    .instr_ready(instr_ready),
    .mem_ready(mem_ready),
    .data(data),
    .program_loaded(program_loaded),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int tx_seen = 0;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t       instr_q[$];
  exp_t       mem_q[$];
  logic [7:0] tx_q[$];
  logic       prev_tx = 1'b0;

  // Output monitor: every pulse must match the head of its expectation queue.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (instr_ready || mem_ready) begin
        tests++;
        assert ((instr_ready && mem_ready) === 1'b0) else begin
          fails++; $error("FAIL excl observed=%b%b required=not both", instr_ready, mem_ready);
        end
      end
      if (instr_ready) begin
        tests++;
        assert (instr_q.size() > 0) else begin
          fails++; $error("FAIL instr_unexpected observed data=%h required=no pulse", data);
        end
        if (instr_q.size() > 0) begin
          e = instr_q.pop_front();
          tests++;
          assert (data === e.d) else begin
            fails++; $error("FAIL instr_data observed=%h required=%h", data, e.d);
          end
          tests++;
          assert (cyc === e.c) else begin
            fails++; $error("FAIL instr_latency observed=%0d required=%0d", cyc, e.c);
          end
        end
      end
      if (mem_ready) begin
        tests++;
        assert (mem_q.size() > 0) else begin
          fails++; $error("FAIL mem_unexpected observed data=%h required=no pulse", data);
        end
        if (mem_q.size() > 0) begin
          e = mem_q.pop_front();
          tests++;
          assert (data === e.d) else begin
            fails++; $error("FAIL mem_data observed=%h required=%h", data, e.d);
          end
          tests++;
          assert (cyc === e.c) else begin
            fails++; $error("FAIL mem_latency observed=%0d required=%0d", cyc, e.c);
          end
        end
      end
      if (tx_start) begin
        tx_seen++;
        tests++;
        assert (prev_tx === 1'b0) else begin
          fails++; $error("FAIL tx_double observed=1 required=0 on previous cycle");
        end
        tests++;
        assert (tx_q.size() > 0) else begin
          fails++; $error("FAIL tx_unexpected observed sdata=%h required=no pulse", sdata);
        end
        if (tx_q.size() > 0) begin
          logic [7:0] b;
          b = tx_q.pop_front();
          tests++;
          assert (sdata === b) else begin
            fails++; $error("FAIL tx_sdata observed=%h required=%h", sdata, b);
          end
        end
      end
    end
    prev_tx = tx_start;
  end

  // kind: 0 = no pulse expected, 1 = instr_ready, 2 = mem_ready
  task automatic send_byte(input logic [7:0] b, input int kind, input logic [31:0] w);
    exp_t e;
    @(negedge clock);
    e.d = w;
    e.c = cyc + 1;
    if (kind == 1) instr_q.push_back(e);
    else if (kind == 2) mem_q.push_back(e);
    rdata    = b;
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int kind);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (i == 3) ? kind : 0, w);
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((instr_q.size() + mem_q.size() + tx_q.size()) != 0 && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    tests++;
    assert ((instr_q.size() + mem_q.size() + tx_q.size()) == 0) else begin
      fails++; $error("FAIL %s observed=%0d pending required=0", tag,
                      instr_q.size() + mem_q.size() + tx_q.size());
    end
  endtask

  task automatic do_reset(input logic busy);
    @(negedge clock);
    reset    = 1'b1;
    rx_ready = 1'b0;
    tx_busy  = busy;
    repeat (2) @(negedge clock);
    tests++;
    assert ({tx_start, sdata, instr_ready, mem_ready, data, program_loaded, instr_count} === '0) else begin
      fails++; $error("FAIL reset_outputs observed tx=%b sdata=%h data=%h pl=%b cnt=%0d required=all 0",
                      tx_start, sdata, data, program_loaded, instr_count);
    end
    reset = 1'b0;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] req);
    tests++;
    assert (obs === req) else begin
      fails++; $error("FAIL %s observed=%h required=%h", tag, obs, req);
    end
  endtask

  initial begin
    // Boot request held off by tx_busy; a byte during S_REQ must be dropped.
    do_reset(1'b1);
    send_byte(8'h55, 0, '0);
    repeat (3) @(negedge clock);
    check32("req_busy_hold", 32'(tx_seen), 32'd0);
    tx_q.push_back(8'h99);
    tx_busy = 1'b0;
    wait_drain("boot_req", 4);

    // Program load of two words.
    send_word(32'd2, 0);
    send_word(32'h00000013, 1);
    tx_q.push_back(8'hAA);
    send_word(32'hDEADBEEF, 1);
    wait_drain("prog_ack", 10);
    check32("prog_loaded", 32'(program_loaded), 32'd1);
    check32("prog_count", instr_count, 32'd2);

    // Run mode: full word, then a word delivered with a pause before its 4th byte.
    send_word(32'h12345678, 2);
    wait_drain("run_word", 4);
    send_byte(8'h11, 0, '0);
    send_byte(8'h22, 0, '0);
    send_byte(8'h33, 0, '0);
    repeat (4) @(negedge clock);
    check32("run_partial_hold", data, 32'h12345678);
    send_byte(8'h44, 2, 32'h44332211);
    wait_drain("run_word2", 4);
    check32("run_count", instr_count, 32'd2);
    check32("run_loaded", 32'(program_loaded), 32'd1);

    // Zero-length program.
    do_reset(1'b0);
    tx_q.push_back(8'h99);
    wait_drain("zl_req", 4);
    tx_q.push_back(8'hAA);
    send_word(32'd0, 0);
    wait_drain("zl_ack", 10);
    check32("zl_loaded", 32'(program_loaded), 32'd1);
    check32("zl_count", instr_count, 32'd0);

    // Overflow: N=3 with a 2-word code segment.
    do_reset(1'b0);
    tx_q.push_back(8'h99);
    wait_drain("ov_req", 4);
    send_word(32'd3, 0);
    send_word(32'hA1A1A1A1, 1);
    send_word(32'hB2B2B2B2, 1);
    tx_q.push_back(8'hAA);
    send_word(32'hC3C3C3C3, 0);
    wait_drain("ov_ack", 10);
    check32("ov_count", instr_count, 32'd2);
    check32("ov_loaded", 32'(program_loaded), 32'd1);

    // Reset after 5 bytes of the instruction stream, then a fresh 1-word load.
    do_reset(1'b0);
    tx_q.push_back(8'h99);
    wait_drain("ml_req", 4);
    send_word(32'd2, 0);
    send_word(32'h01020304, 1);
    send_byte(8'h77, 0, '0);
    wait_drain("ml_first", 4);
    do_reset(1'b0);
    tx_q.push_back(8'h99);
    wait_drain("ml_req_2cyc", 2);
    send_word(32'd1, 0);
    tx_q.push_back(8'hAA);
    send_word(32'hCAFEF00D, 1);
    wait_drain("ml_ack", 10);
    check32("ml_count", instr_count, 32'd1);
    check32("ml_loaded", 32'(program_loaded), 32'd1);
    check32("ml_data", data, 32'hCAFEF00D);

    repeat (4) @(negedge clock);
    wait_drain("final", 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_dma_loader.md
Name: uart_dma_loader

Overview:
Boot-time and run-time DMA front end sitting between UartRx/UartTx and the memory controller hub.
- At boot it handshakes with the host, receives a word count, then streams that many little-endian 32-bit instruction words as `instr_ready` pulses.
- It then sends an acknowledge byte and switches to run mode, where every further 4 received bytes become one `mem_ready` pulse into the input-data ring buffer.
- It drives UartTx only while booting.

Parameters:
- BOOT_REQ_BYTE, 8'h99, byte sent to host to request a program.
- BOOT_ACK_BYTE, 8'hAA, byte sent to host after the last instruction word.
- MAX_INSTR_WORDS, 256, capacity of the code segment in words; instruction words beyond this are consumed but not forwarded.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_ready  in  1  one-cycle pulse, new byte valid on rdata
- rdata  in  8  received UART byte
- tx_busy  in  1  UartTx busy
- tx_start  out  1  one-cycle pulse to start a UART transmission
- sdata  out  8  byte to transmit; valid with tx_start
- instr_ready  out  1  one-cycle pulse, data holds an instruction word
- mem_ready  out  1  one-cycle pulse, data holds an input-data word
- data  out  32  assembled word
- program_loaded  out  1  high from entry to S_RUN until reset
- instr_count  out  32  number of instruction words forwarded so far

Behaviour:
- Reset (clock, reset, synchronous, active-high; clock is clock): the state machine enters S_REQ and all outputs are 0, including data, sdata and instr_count.
  - Byte index, word count and the assembly shift register are cleared.
  - Reset mid-operation aborts any partial word and restarts the boot handshake.
- Byte assembly:
  - Little-endian: byte k of a word goes to data[8k+7:8k].
  - A 2-bit byte index increments on each accepted rx_ready and wraps 3->0.
  - When the 4th byte is accepted (index==3), the word is complete.
  - Completion causes `data` to be registered and the matching ready output to pulse on the next cycle (1-cycle latency from the 4th rx_ready).
  - `data` holds its value until the next completed word.
- States:
  - S_REQ:
    - When tx_busy==0, pulse tx_start for 1 cycle with sdata=BOOT_REQ_BYTE, then go to S_LEN.
    - rx bytes arriving in S_REQ are dropped and the byte index is not advanced.
  - S_LEN:
    - Assemble one word into the internal counter N; no ready pulse is produced.
    - If N==0, go to S_ACK; otherwise go to S_INSTR.
  - S_INSTR:
    - Each completed word pulses instr_ready if instr_count < MAX_INSTR_WORDS, and instr_count increments on that pulse.
    - Words beyond MAX_INSTR_WORDS are counted toward N but do not pulse instr_ready.
    - After the N-th word, go to S_ACK.
  - S_ACK:
    - Wait until tx_busy==0 and tx_start==0, then pulse tx_start with sdata=BOOT_ACK_BYTE and go to S_RUN.
    - Assembly remains active in S_ACK. A word completed in S_ACK pulses mem_ready, and a partial word carries over into S_RUN.
  - S_RUN:
    - Each completed word pulses mem_ready.
    - tx_start is never asserted again, so the hub owns UartTx from this point.
    - program_loaded=1 from the first S_RUN cycle onward.
- Exclusivity: instr_ready and mem_ready are never high in the same cycle; tx_start is never high for 2 consecutive cycles.
- Word counter: 32-bit, compared with the unsigned received N. N=0xFFFFFFFF is legal; the block simply stays in S_INSTR.
- Simultaneity: a rx_ready in the same cycle as a state transition is accepted by the state being left. The word it completes is attributed to that state, e.g. the N-th instruction word still pulses instr_ready.

Test Plan:
- Boot request: release reset with tx_busy=0 -> tx_start pulses exactly once with sdata=8'h99 within 2 cycles; with tx_busy held high, tx_start stays low until tx_busy falls.
- Program load: send bytes 02 00 00 00, 13 00 00 00, EF BE AD DE -> instr_ready pulses twice, with data=32'h00000013 then 32'hDEADBEEF, each 1 cycle after its 4th rx_ready. Then tx_start pulses with sdata=8'hAA and program_loaded=1; instr_count=2.
- Zero-length program: send 00 00 00 00 -> no instr_ready; the ACK byte is sent and program_loaded=1.
- Run-mode data: after boot, send 78 56 34 12 -> one mem_ready pulse with data=32'h12345678. Sending 3 more bytes yields no pulse; the 4th yields a pulse. No tx_start is asserted.
- Overflow: MAX_INSTR_WORDS=2, N=3 -> exactly 2 instr_ready pulses, the third word is swallowed, then ACK is sent; instr_count=2.
- Reset mid-load: assert reset after 5 bytes of the instruction stream -> all outputs return to 0 and a new 8'h99 request is sent. A fresh load of 1 word then works correctly.
